// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache.
//
// A fetch request that hits returns its word one cycle later. A miss issues a
// single fill request to the memory controller, waits for the controller to
// accept it and finish, then writes the line and returns the word. A flush
// (fence.i) invalidates every line. If the flush arrives while a fill is in
// flight, the handshake still finishes but the fill data is discarded.
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   rdy_i        global enable; when low, all state and outputs hold
//   if_req_i     fetch request, held with if_addr_i until if_valid_o
//   if_addr_i    fetch byte address (bits [1:0] ignored)
//   flush_i      invalidate all lines
//   if_data_o    returned instruction word (holds its last value)
//   if_valid_o   one-cycle pulse, if_data_o belongs to the current request
//   inst_re_o    fill request to the memory controller
//   inst_addr_o  word-aligned fill address
//   inst_data_i  fill data, valid in the cycle inst_busy_i falls
//   inst_busy_i  memory controller fill in progress
// -----------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic [31:0] if_data_o,
  output logic        if_valid_o,
  output logic        inst_re_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_data_i,
  input  logic        inst_busy_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_e;

  state_e              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];
  logic [31:0]         if_data_q;
  logic                if_valid_q;
  logic                inst_re_q;
  logic [31:0]         inst_addr_q;
  // Set when a flush lands while a fill is in flight: the fill is then stale.
  logic                fill_stale_q;

  // Lookup uses the live request address; the fill uses the latched miss
  // address so it does not depend on the fetch stage holding if_addr_i.
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;
  logic                  fill_done;
  logic                  fill_we;
  logic                  unused_addr_bits;

  assign req_idx   = if_addr_i[2+INDEX_BITS-1:2];
  assign req_tag   = if_addr_i[ADDR_BITS-1:2+INDEX_BITS];
  assign fill_idx  = inst_addr_q[2+INDEX_BITS-1:2];
  assign fill_tag  = inst_addr_q[ADDR_BITS-1:2+INDEX_BITS];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A fill completes when the controller drops busy in MISS_WAIT; it is only
  // kept if no flush hit this fill, including one in the very same cycle.
  assign fill_done = (state_q == MISS_WAIT) && !inst_busy_i;
  assign fill_we   = !rst_i && rdy_i && fill_done && !flush_i && !fill_stale_q;

  assign unused_addr_bits = ^if_addr_i[1:0];

  // Controller, valid bits and registered outputs.
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      if_data_q    <= '0;
      if_valid_q   <= 1'b0;
      inst_re_q    <= 1'b0;
      inst_addr_q  <= '0;
      fill_stale_q <= 1'b0;
    end else if (rdy_i) begin
      if_valid_q <= 1'b0;
      if (flush_i) valid_q <= '0;
      case (state_q)
        IDLE: begin
          // The cycle if_valid is high still shows the old request: skip it.
          if (if_req_i && !flush_i && !if_valid_q) begin
            if (hit) begin
              if_data_q  <= data_q[req_idx];
              if_valid_q <= 1'b1;
            end else begin
              inst_re_q    <= 1'b1;
              inst_addr_q  <= {if_addr_i[31:2], 2'b00};
              fill_stale_q <= 1'b0;
              state_q      <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (flush_i) fill_stale_q <= 1'b1;
          if (inst_busy_i) begin
            inst_re_q <= 1'b0;
            state_q   <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (flush_i) fill_stale_q <= 1'b1;
          if (fill_done) begin
            state_q <= IDLE;
            if (fill_we) begin
              valid_q[fill_idx] <= 1'b1;
              if_data_q         <= inst_data_i;
              if_valid_q        <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only read once its
  // valid bit is set, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= inst_data_i;
    end
  end

  assign if_data_o   = if_data_q;
  assign if_valid_o  = if_valid_q;
  assign inst_re_o   = inst_re_q;
  assign inst_addr_o = inst_addr_q;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache.
// A vector table covers the directed fetch cases, hand-written sequences cover
// flush, rdy stalls and reset in the middle of a fill, and a randomized phase
// compares against a line-level model of a direct-mapped cache.
// -----------------------------------------------------------------------------
module tb_icache;

  localparam int INDEX_BITS = 6;
  localparam int ADDR_BITS  = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_data;
  logic        if_valid;
  logic        inst_re;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache #(.INDEX_BITS(INDEX_BITS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rdy_i       (rdy),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .flush_i     (flush),
    .if_data_o   (if_data),
    .if_valid_o  (if_valid),
    .inst_re_o   (inst_re),
    .inst_addr_o (inst_addr),
    .inst_data_i (inst_data),
    .inst_busy_i (inst_busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Backing memory contents as seen by the memory controller.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0104) return 32'h0041_0113;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: each index remembers which word it holds and its data.
  logic [31:0] m_data [int];
  logic [31:0] m_key  [int];

  function automatic int m_index(input logic [31:0] a);
    return int'(a[2+INDEX_BITS-1:2]);
  endfunction

  function automatic logic [31:0] m_keyof(input logic [31:0] a);
    return a & ((32'h1 << ADDR_BITS) - 32'h4);
  endfunction

  // One fetch with a responsive memory controller model. gd: cycles of inst_re
  // before busy is raised; fd: cycles busy stays high.
  task automatic fetch(input logic [31:0] addr, input int gd, input int fd,
                       output logic [31:0] data, output bit missed, output bit ok,
                       output bit proto_ok, output int lat);
    int  cnt;
    bit  granted;
    bit  fill_sent;
    cnt = 0; granted = 0; fill_sent = 0;
    missed = 0; ok = 0; proto_ok = 1; data = '0; lat = 0;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = addr;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk);
      if (if_valid) begin
        data = if_data;
        ok   = 1;
        lat  = cyc + 1;
        if ((missed && !fill_sent) || inst_re) proto_ok = 0;
      end else if (!granted) begin
        if (inst_re) begin
          if (!missed) begin
            missed = 1;
            check("inst_addr", inst_addr, {addr[31:2], 2'b00});
          end
          if (cnt == gd) begin
            inst_busy = 1'b1;
            granted   = 1;
            cnt       = 0;
          end else begin
            cnt++;
          end
        end else if (missed) begin
          proto_ok = 0;
        end
      end else begin
        if (inst_re) proto_ok = 0;
        if (inst_busy) begin
          if (cnt == fd) begin
            inst_busy = 1'b0;
            inst_data = mem_word(addr);
            fill_sent = 1;
          end else begin
            cnt++;
          end
        end
      end
    end
    if_req    = 1'b0;
    inst_busy = 1'b0;
    inst_data = 32'hDEAD_BEEF;
  endtask

  task automatic do_fetch(input string name, input logic [31:0] addr, input int gd,
                          input int fd, input bit exp_miss, input logic [31:0] exp_data);
    logic [31:0] data;
    bit          missed, ok, proto_ok;
    int          lat;
    fetch(addr, gd, fd, data, missed, ok, proto_ok, lat);
    check({name, " done"},  {31'd0, ok}, 32'd1);
    check({name, " miss"},  {31'd0, missed}, {31'd0, exp_miss});
    check({name, " data"},  data, exp_data);
    check({name, " proto"}, {31'd0, proto_ok}, 32'd1);
    if (!exp_miss) check({name, " latency"}, lat, 32'd1);
  endtask

  // Fetch checked against the reference model, which is then updated.
  task automatic model_fetch(input string name, input logic [31:0] addr, input int gd, input int fd);
    int          idx;
    bit          exp_hit;
    logic [31:0] exp_data;
    idx     = m_index(addr);
    exp_hit = m_key.exists(idx) && (m_key[idx] == m_keyof(addr));
    exp_data = exp_hit ? m_data[idx] : mem_word(addr);
    do_fetch(name, addr, gd, fd, !exp_hit, exp_data);
    m_key[idx]  = m_keyof(addr);
    m_data[idx] = exp_data;
  endtask

  task automatic model_clear();
    m_key.delete();
    m_data.delete();
  endtask

  task automatic do_flush(input bit with_req, input logic [31:0] addr);
    @(negedge clk);
    flush   = 1'b1;
    if_req  = with_req;
    if_addr = addr;
    @(negedge clk);
    flush  = 1'b0;
    if_req = 1'b0;
    if (with_req) begin
      check("flush+req valid", {31'd0, if_valid}, 32'd0);
      check("flush+req re",    {31'd0, inst_re},  32'd0);
    end
  endtask

  task automatic wait_re(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = inst_re;
    end
    check({name, " inst_re seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Miss on addr, flush while the fill is outstanding; the flush either comes
  // one cycle before busy drops or in the very cycle it drops.
  task automatic flushed_fill(input string name, input logic [31:0] addr, input bit same_cycle);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    wait_re(name);
    inst_busy = 1'b1;
    @(negedge clk);
    check({name, " re dropped"}, {31'd0, inst_re}, 32'd0);
    flush = 1'b1; if_req = 1'b0;
    if (same_cycle) begin
      inst_busy = 1'b0; inst_data = 32'hCAFE_0001;
    end
    @(negedge clk);
    flush = 1'b0;
    inst_busy = 1'b0; inst_data = 32'hCAFE_0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, " no valid"}, {31'd0, if_valid}, 32'd0);
      check({name, " no re"},    {31'd0, inst_re},  32'd0);
    end
    model_clear();
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gd;
    int          fd;
    bit          exp_miss;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst = 1'b1; rdy = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    inst_data = '0; inst_busy = 1'b0;

    // Reset wins over rdy=0.
    repeat (3) @(negedge clk);
    check("reset if_valid",  {31'd0, if_valid}, 32'd0);
    check("reset if_data",   if_data, 32'd0);
    check("reset inst_re",   {31'd0, inst_re}, 32'd0);
    check("reset inst_addr", inst_addr, 32'd0);
    rst = 1'b0; rdy = 1'b1;

    vecs[0]  = '{32'h0000_0104,  2, 1, 1'b1, 32'h0041_0113};
    vecs[1]  = '{32'h0000_0104,  0, 0, 1'b0, 32'h0041_0113};
    vecs[2]  = '{32'h0000_0107,  0, 0, 1'b0, 32'h0041_0113};
    vecs[3]  = '{32'h0000_0204,  1, 2, 1'b1, mem_word(32'h204)};
    vecs[4]  = '{32'h0000_0104,  0, 0, 1'b1, 32'h0041_0113};
    vecs[5]  = '{32'h0000_0108,  0, 3, 1'b1, mem_word(32'h108)};
    vecs[6]  = '{32'h0000_0108,  0, 0, 1'b0, mem_word(32'h108)};
    vecs[7]  = '{32'h0004_0104,  0, 0, 1'b0, 32'h0041_0113};
    vecs[8]  = '{32'h0001_0104,  0, 0, 1'b1, mem_word(32'h10104)};
    vecs[9]  = '{32'h0000_0104,  0, 0, 1'b1, 32'h0041_0113};
    vecs[10] = '{32'h0000_030C, 10, 1, 1'b1, mem_word(32'h30C)};
    vecs[11] = '{32'h0000_030C,  0, 0, 1'b0, mem_word(32'h30C)};
    for (int i = 0; i < 12; i++)
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].gd, vecs[i].fd,
               vecs[i].exp_miss, vecs[i].exp_data);

    // Request presented while if_valid is still high is not accepted.
    do_fetch("b2b first", 32'h104, 0, 0, 1'b0, 32'h0041_0113);
    if_req = 1'b1; if_addr = 32'h30C;
    @(negedge clk);
    check("b2b ignored", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    check("b2b second valid", {31'd0, if_valid}, 32'd1);
    check("b2b second data",  if_data, mem_word(32'h30C));
    if_req = 1'b0;

    // Flush in IDLE clears cached 0x104 and drops the concurrent request.
    do_flush(1'b1, 32'h104);
    do_fetch("post-flush 104", 32'h104, 0, 0, 1'b1, 32'h0041_0113);

    // Flush while the 0x108 fill is in MISS_WAIT, then same-cycle variant.
    flushed_fill("flush wait", 32'h108, 1'b0);
    do_fetch("after flush 104", 32'h104, 0, 0, 1'b1, 32'h0041_0113);
    do_fetch("after flush 108", 32'h108, 1, 0, 1'b1, mem_word(32'h108));
    flushed_fill("flush same", 32'h208, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    do_fetch("after same 208", 32'h208, 0, 1, 1'b1, mem_word(32'h208));

    // rdy=0 holds inst_re in MISS_REQ and defers the capture in MISS_WAIT.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h404;
    wait_re("stall");
    rdy = 1'b0; inst_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall re held", {31'd0, inst_re}, 32'd1);
      check("stall addr held", inst_addr, 32'h404);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("stall grant", {31'd0, inst_re}, 32'd0);
    rdy = 1'b0; inst_busy = 1'b0; inst_data = mem_word(32'h404);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall no valid", {31'd0, if_valid}, 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("stall valid", {31'd0, if_valid}, 32'd1);
    check("stall data",  if_data, mem_word(32'h404));
    if_req = 1'b0; inst_data = 32'hDEAD_BEEF;
    do_fetch("stall rehit", 32'h404, 0, 0, 1'b0, mem_word(32'h404));

    // Reset in the middle of a fill abandons it.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h50C;
    wait_re("rst fill");
    inst_busy = 1'b1;
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst re",    {31'd0, inst_re},  32'd0);
    check("rst valid", {31'd0, if_valid}, 32'd0);
    check("rst data",  if_data, 32'd0);
    inst_busy = 1'b0; inst_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst ignore busy valid", {31'd0, if_valid}, 32'd0);
      check("rst ignore busy re",    {31'd0, inst_re},  32'd0);
    end
    model_clear();
    model_fetch("rst refetch", 32'h404, 0, 0);

    // Randomized fetches over a few indices and tags against the model.
    do_flush(1'b0, 32'h0);
    model_clear();
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) begin
        do_flush(1'b0, 32'h0);
        model_clear();
      end else begin
        a = ($urandom_range(0, 1) << 20) | ($urandom_range(0, 2) << 8) |
            ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        model_fetch($sformatf("rnd%0d", n), a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
